// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit MIPS core: byte-serial fetch, decode, execute and writeback.
// Define MIPS_ADDI_EN to decode ADDI (ADDIEX/ADDIWR); otherwise opcode 001000 is illegal.
//
// state   | meaning
// --------+-------------------------------------------------
// FETCH1-4| load IR byte n-1, PC += 1; hold while !mem_ready
// DECODE  | precompute branch target, dispatch on opcode
// MEMADR  | compute load/store address A + imm
// LBRD    | read memory at ALUOut; hold while !mem_ready
// LBWR    | write MDR into rt
// SBWR    | write B to memory at ALUOut; hold while !mem_ready
// RTYPEEX | A funct B
// RTYPEWR | write ALUOut into rd
// BEQEX   | compare A-B, branch to ALUOut on zero
// JEX     | load jump target into PC
// ADDIEX  | A + imm
// ADDIWR  | write ALUOut into rt
module mips_multicycle_ctrl (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_write,
   output logic [3:0] ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       illegal_op,
   output logic [7:0] instr_count
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_ADDI_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

   typedef enum logic [3:0] {
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_DECODE, S_MEMADR,
      S_LBRD, S_LBWR, S_SBWR, S_RTYPEEX, S_RTYPEWR, S_BEQEX, S_JEX
`ifdef MIPS_ADDI_EN
      , S_ADDIEX, S_ADDIWR
`endif
   } state_t;

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [7:0] count_q;
   logic       retire;
   logic       pc_write;
   logic       branch;
   logic       mem_write_raw;
   logic       reg_write_raw;
   logic [3:0] ir_write_raw;

   always_comb begin
      state_d       = state_q;
      illegal_d     = 1'b0;
      retire        = 1'b0;
      pc_write      = 1'b0;
      branch        = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      ir_write_raw  = 4'b0000;
      iord          = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_src        = 2'b00;

      case (state_q)
         S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
            alu_src_b = 2'b01;
            pc_write  = mem_ready;
            if (mem_ready) begin
               case (state_q)
                  S_FETCH1: begin ir_write_raw = 4'b0001; state_d = S_FETCH2; end
                  S_FETCH2: begin ir_write_raw = 4'b0010; state_d = S_FETCH3; end
                  S_FETCH3: begin ir_write_raw = 4'b0100; state_d = S_FETCH4; end
                  default:  begin ir_write_raw = 4'b1000; state_d = S_DECODE; end
               endcase
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LB, OP_SB: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_J:         state_d = S_JEX;
`ifdef MIPS_ADDI_EN
               OP_ADDI:      state_d = S_ADDIEX;
`endif
               default: begin
                  state_d   = S_FETCH1;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_SB) ? S_SBWR : S_LBRD;
         end
         S_LBRD: begin
            iord = 1'b1;
            if (mem_ready) state_d = S_LBWR;
         end
         S_LBWR: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = 1'b1;
            retire        = 1'b1;
            state_d       = S_FETCH1;
         end
         S_SBWR: begin
            iord          = 1'b1;
            mem_write_raw = mem_ready;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH1;
            end
         end
         S_RTYPEEX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_RTYPEWR;
         end
         S_RTYPEWR: begin
            reg_write_raw = 1'b1;
            reg_dst       = 1'b1;
            retire        = 1'b1;
            state_d       = S_FETCH1;
         end
         S_BEQEX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch    = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH1;
         end
         S_JEX: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH1;
         end
`ifdef MIPS_ADDI_EN
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDIWR;
         end
         S_ADDIWR: begin
            reg_write_raw = 1'b1;
            retire        = 1'b1;
            state_d       = S_FETCH1;
         end
`endif
         default: state_d = S_FETCH1;
      endcase
   end

   // Strobes are suppressed while reset is held; selects already show FETCH1 values.
   assign pc_en     = ~reset & (pc_write | (branch & zero));
   assign mem_write = ~reset & mem_write_raw;
   assign reg_write = ~reset & reg_write_raw;
   assign ir_write  = reset ? 4'b0000 : ir_write_raw;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH1;
         illegal_q <= 1'b0;
         count_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         if (retire) count_q <= count_q + 8'd1;
      end
   end

   assign illegal_op  = illegal_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed and random instruction streams against a step-list model.
// Follows MIPS_ADDI_EN the same way as the design.
module tb_mips_multicycle_ctrl;

   logic       clock, reset, zero, mem_ready;
   logic [5:0] opcode;
   logic       pc_en, iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
   logic [3:0] ir_write;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [7:0] instr_count;

   mips_multicycle_ctrl dut (
      .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .illegal_op(illegal_op), .instr_count(instr_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [16:0] dut_vec;
   assign dut_vec = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, alu_op, pc_src};

   localparam logic [16:0] RST_VEC = 17'h00010;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] cnt;
   logic       exp_ill;
   bit         cur_illegal;
   int         stall_mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_illegal(input logic [5:0] op);
      case (op)
         6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010: return 1'b0;
`ifdef MIPS_ADDI_EN
         6'b001000: return 1'b0;
`endif
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit is_mem(input string st);
      return (st == "FETCH1" || st == "FETCH2" || st == "FETCH3" || st == "FETCH4" ||
              st == "LBRD" || st == "SBWR");
   endfunction

   function automatic bit retires(input string st);
      return (st == "LBWR" || st == "SBWR" || st == "RTYPEWR" || st == "BEQEX" ||
              st == "JEX" || st == "ADDIWR");
   endfunction

   // Expected control word for one step, straight from the per-state output list.
   function automatic logic [16:0] exp_vec(input string st, input logic z, input logic rdy);
      logic pe, io, mw, rw, rd, m2r, sa;
      logic [3:0] ir;
      logic [1:0] sb, op, ps;
      {pe, io, mw, rw, rd, m2r, sa} = '0;
      ir = '0; sb = '0; op = '0; ps = '0;
      if (st == "FETCH1" || st == "FETCH2" || st == "FETCH3" || st == "FETCH4") begin
         sb = 2'b01;
         pe = rdy;
         if (rdy) begin
            if (st == "FETCH1") ir = 4'd1;
            else if (st == "FETCH2") ir = 4'd2;
            else if (st == "FETCH3") ir = 4'd4;
            else ir = 4'd8;
         end
      end else if (st == "DECODE") sb = 2'b11;
      else if (st == "MEMADR" || st == "ADDIEX") begin sa = 1; sb = 2'b10; end
      else if (st == "LBRD") io = 1;
      else if (st == "LBWR") begin rw = 1; m2r = 1; end
      else if (st == "SBWR") begin io = 1; mw = rdy; end
      else if (st == "RTYPEEX") begin sa = 1; op = 2'b10; end
      else if (st == "RTYPEWR") begin rw = 1; rd = 1; end
      else if (st == "BEQEX") begin sa = 1; op = 2'b01; ps = 2'b01; pe = z; end
      else if (st == "JEX") begin ps = 2'b10; pe = 1; end
      else if (st == "ADDIWR") rw = 1;
      return {pe, io, mw, ir, rw, rd, m2r, sa, sb, op, ps};
   endfunction

   task automatic do_step(input string st, input bit force_z, input logic bz);
      int  stalls = 0;
      bit  done = 0;
      logic rdy, z;
      while (!done) begin
         case (stall_mode)
            0: rdy = 1'b1;
            1: rdy = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            default: rdy = (st == "FETCH2" && stalls < 3) ? 1'b0 : 1'b1;
         endcase
         if (!is_mem(st) && stall_mode == 1) rdy = $urandom_range(0, 1);
         z = (force_z && st == "BEQEX") ? bz : logic'($urandom_range(0, 1));
         mem_ready = rdy;
         zero = z;
         @(negedge clock);
         chk({"ctrl_", st}, 32'(dut_vec), 32'(exp_vec(st, z, rdy)));
         chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
         chk("instr_count", 32'(instr_count), 32'(cnt));
         @(posedge clock);
         #1;
         exp_ill = (st == "DECODE") && cur_illegal;
         if (!is_mem(st) || rdy) begin
            done = 1;
            if (retires(st)) cnt = cnt + 8'd1;
         end else stalls++;
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input bit force_z, input logic bz);
      string q[$];
      opcode = op;
      cur_illegal = is_illegal(op);
      q = '{"FETCH1", "FETCH2", "FETCH3", "FETCH4", "DECODE"};
      case (op)
         6'b100000: begin q.push_back("MEMADR"); q.push_back("LBRD"); q.push_back("LBWR"); end
         6'b101000: begin q.push_back("MEMADR"); q.push_back("SBWR"); end
         6'b000000: begin q.push_back("RTYPEEX"); q.push_back("RTYPEWR"); end
         6'b000100: q.push_back("BEQEX");
         6'b000010: q.push_back("JEX");
         6'b001000: if (!cur_illegal) begin q.push_back("ADDIEX"); q.push_back("ADDIWR"); end
         default: ;
      endcase
      foreach (q[i]) do_step(q[i], force_z, bz);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      mem_ready = 1'b1;
      #3;
      chk("reset_ctrl", 32'(dut_vec), 32'(RST_VEC));
      chk("reset_count", 32'(instr_count), 32'd0);
      chk("reset_illegal", 32'(illegal_op), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cnt = 8'd0;
      exp_ill = 1'b0;
   endtask

   initial begin
      logic [5:0] rop;
      reset = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = 6'd0;
      cnt = 8'd0; exp_ill = 1'b0; cur_illegal = 0; stall_mode = 0;
      #2;
      apply_reset();

      run_instr(6'b000000, 0, 0);
      chk("rtype_count", 32'(instr_count), 32'd1);
      stall_mode = 2;
      run_instr(6'b000000, 0, 0);
      stall_mode = 0;
      run_instr(6'b000100, 1, 1'b1);
      run_instr(6'b000100, 1, 1'b0);
      run_instr(6'b100000, 0, 0);
      run_instr(6'b101000, 0, 0);
      run_instr(6'b111111, 0, 0);
      run_instr(6'b001000, 0, 0);
      run_instr(6'b000010, 0, 0);

      stall_mode = 1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0: rop = 6'b000000;
            1: rop = 6'b100000;
            2: rop = 6'b101000;
            3: rop = 6'b000100;
            4: rop = 6'b000010;
            5: rop = 6'b001000;
            6: rop = 6'($urandom_range(0, 63));
            default: rop = 6'b111111;
         endcase
         run_instr(rop, 0, 0);
      end

      stall_mode = 0;
      apply_reset();
      for (int i = 0; i < 256; i++) run_instr(6'b000010, 0, 0);
      chk("wrap_count", 32'(instr_count), 32'd0);

      opcode = 6'b100000;
      cur_illegal = 0;
      do_step("FETCH1", 0, 0);
      do_step("FETCH2", 0, 0);
      do_step("FETCH3", 0, 0);
      do_step("FETCH4", 0, 0);
      do_step("DECODE", 0, 0);
      do_step("MEMADR", 0, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_ctrl", 32'(dut_vec), 32'(RST_VEC));
      chk("async_reset_count", 32'(instr_count), 32'd0);
      @(negedge clock);
      chk("async_reset_hold", 32'(dut_vec), 32'(RST_VEC));
      @(posedge clock);
      #1;
      reset = 1'b0;
      cnt = 8'd0;
      exp_ill = 1'b0;
      run_instr(6'b100000, 0, 0);
      chk("post_reset_count", 32'(instr_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
